// File: rtl/bloom_query_engine.sv
// Bloom-filter insert/query engine: two fixed hashes into a 64-bit filter,
// valid/ready request and response channels, and a sequenced word-wise clear.
module bloom_query_engine #(
    parameter int DATA_W = 8,
    parameter int M_LOG2 = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic              rsp_new,
    output logic [CNT_W-1:0]  distinct_count,
    output logic              busy
);
    localparam int M      = 1 << M_LOG2;
    localparam int WORDS  = M / 8;
    localparam int WIDX_W = $clog2(WORDS);
    localparam logic [WIDX_W-1:0] LAST_W = WIDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP, CLEAR} state_t;

    state_t                   state, state_nxt;
    logic [WORDS-1:0][7:0]    filter;
    logic [M-1:0]             filter_flat;
    logic [M-1:0]             set_mask;
    logic [M_LOG2-1:0]        h0, h1, h0_in, h1_in;
    logic [7:0]               mixed;
    logic                     op;
    logic                     clr_pending;
    logic                     pre_hit;
    logic [WIDX_W-1:0]        widx;

    // h1 mixes the key by rotate-left-3 then XOR with a constant
    assign mixed       = {req_data[4:0], req_data[7:5]} ^ 8'hA5;
    assign h0_in       = req_data[M_LOG2-1:0];
    assign h1_in       = mixed[M_LOG2-1:0];
    assign filter_flat = filter;
    assign pre_hit     = filter_flat[h0] & filter_flat[h1];
    assign set_mask    = (M'(1) << h0) | (M'(1) << h1);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !clr && !clr_pending;
                if (clr || clr_pending) state_nxt = CLEAR;
                else if (req_valid)     state_nxt = LOOKUP;
            end
            LOOKUP:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            CLEAR:   if (widx == LAST_W) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            filter         <= '0;
            distinct_count <= '0;
            clr_pending    <= 1'b0;
            widx           <= '0;
            op             <= 1'b0;
            h0             <= '0;
            h1             <= '0;
            rsp_valid      <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_new        <= 1'b0;
        end else begin
            state <= state_nxt;
            // a clear requested while busy is remembered and run once back in IDLE
            if (clr && state != IDLE) clr_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr || clr_pending) begin
                        widx        <= '0;
                        clr_pending <= 1'b0;
                    end else if (req_valid) begin
                        op <= req_op;
                        h0 <= h0_in;
                        h1 <= h1_in;
                    end
                end
                LOOKUP: begin
                    rsp_valid <= 1'b1;
                    rsp_hit   <= pre_hit;
                    rsp_new   <= op && !pre_hit;
                    if (op) begin
                        filter <= filter_flat | set_mask;
                        if (!pre_hit && !(&distinct_count))
                            distinct_count <= distinct_count + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                CLEAR: begin
                    filter[widx] <= 8'h00;
                    widx         <= widx + 1'b1;
                    if (widx == LAST_W) distinct_count <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bloom_query_engine.sv
// Bench for bloom_query_engine: directed scenarios plus a randomized run,
// all cycles checked against a transaction-level model of the filter.
module tb_bloom_query_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        clr, req_valid, req_op, rsp_ready;
    logic [7:0]  req_data;
    logic        req_ready, rsp_valid, rsp_hit, rsp_new, busy;
    logic [15:0] distinct_count;
    logic        s_req_ready, s_rsp_valid, s_rsp_hit, s_rsp_new, s_busy;
    logic [1:0]  s_count;

    int n_cmp = 0;
    int n_bad = 0;

    bloom_query_engine #(.DATA_W(8), .M_LOG2(6), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_new(rsp_new),
        .distinct_count(distinct_count), .busy(busy)
    );

    // narrow counter copy so saturation is reachable within one filter lifetime
    bloom_query_engine #(.DATA_W(8), .M_LOG2(6), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .clr(clr),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(s_rsp_hit), .rsp_new(s_rsp_new),
        .distinct_count(s_count), .busy(s_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    function automatic int hash0(input int d);
        return d % 64;
    endfunction

    function automatic int hash1(input int d);
        int r;
        r = ((d * 8) % 256) + (d / 32);
        return (r ^ 'hA5) % 64;
    endfunction

    // model: filter as a bit array, operations as pending transactions
    bit mf[64];
    int mcnt, scnt, clr_left;
    bit mpend, lk, rv, rh, rn, mop, m_idle;
    int mkey;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            foreach (mf[i]) mf[i] = 1'b0;
            mcnt = 0; scnt = 0; clr_left = 0;
            mpend = 0; lk = 0; rv = 0; rh = 0; rn = 0;
        end else begin
            m_idle = !lk && !rv && clr_left == 0;
            if (clr && !m_idle) mpend = 1;
            if (clr_left > 0) begin
                clr_left--;
                if (clr_left == 0) begin
                    foreach (mf[i]) mf[i] = 1'b0;
                    mcnt = 0; scnt = 0;
                end
            end else if (lk) begin
                rh = mf[hash0(mkey)] && mf[hash1(mkey)];
                rn = mop && !rh;
                if (mop) begin
                    mf[hash0(mkey)] = 1'b1;
                    mf[hash1(mkey)] = 1'b1;
                    if (!rh) begin
                        if (mcnt < 65535) mcnt++;
                        if (scnt < 3) scnt++;
                    end
                end
                lk = 0; rv = 1;
            end else if (rv) begin
                if (rsp_ready) rv = 0;
            end else if (clr || mpend) begin
                clr_left = 8; mpend = 0;
            end else if (req_valid) begin
                lk = 1; mop = req_op; mkey = int'(req_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            m_idle = !lk && !rv && clr_left == 0;
            chk("rsp_valid", rsp_valid, rv);
            chk("busy", busy, !m_idle);
            chk("req_ready", req_ready, m_idle && !clr && !mpend);
            chk("count", distinct_count, mcnt);
            chk("s_count", s_count, scnt);
            chk("s_rsp_valid", s_rsp_valid, rv);
            if (rv) begin
                chk("rsp_hit", rsp_hit, rh);
                chk("rsp_new", rsp_new, rn);
                chk("s_rsp_new", s_rsp_new, rn);
            end
        end
    end

    task automatic do_op(input bit op, input logic [7:0] d,
                         output bit h, output bit n, output bit sn, output int lat);
        int t;
        h = 0; n = 0; sn = 0; lat = 0; t = 0;
        req_valid = 1; req_op = op; req_data = d;
        @(negedge clk);
        while (!req_ready && t < 50) begin t++; @(negedge clk); end
        if (!req_ready) begin timeout("req_handshake"); req_valid = 0; return; end
        @(posedge clk); #1 req_valid = 0; lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        if (!rsp_valid) begin timeout("rsp_wait"); return; end
        h = rsp_hit; n = rsp_new; sn = s_rsp_new;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 reset = 1;
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic count_busy(input int start, output int n);
        n = start;
        @(negedge clk);
        while (busy && n < 40) begin n++; @(negedge clk); end
        @(posedge clk); #1;
    endtask

    initial begin
        bit h, n, sn;
        int lat, nb;
        clr = 0; req_valid = 0; req_op = 0; req_data = 0; rsp_ready = 1; reset = 0;
        #1 reset = 1;
        #3;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", distinct_count, 0);
        chk("reset_hit", rsp_hit, 0);
        chk("reset_new", rsp_new, 0);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;

        do_op(0, 8'h00, h, n, sn, lat);
        chk("q00_hit", h, 0); chk("q00_new", n, 0); chk("q00_lat", lat, 2);
        chk("q00_count", distinct_count, 0);
        do_op(1, 8'h00, h, n, sn, lat);
        chk("i00_hit", h, 0); chk("i00_new", n, 1); chk("i00_count", distinct_count, 1);
        do_op(1, 8'h00, h, n, sn, lat);
        chk("i00b_hit", h, 1); chk("i00b_new", n, 0); chk("i00b_count", distinct_count, 1);
        do_op(0, 8'h00, h, n, sn, lat);
        chk("q00b_hit", h, 1);
        do_op(1, 8'h01, h, n, sn, lat);
        chk("i01_hit", h, 0); chk("i01_new", n, 1); chk("i01_count", distinct_count, 2);

        pulse_reset();
        do_op(1, 8'h40, h, n, sn, lat);
        do_op(1, 8'h25, h, n, sn, lat);
        chk("fp_count", distinct_count, 2);
        do_op(0, 8'h00, h, n, sn, lat);
        chk("fp_qhit", h, 1);
        do_op(1, 8'h00, h, n, sn, lat);
        chk("fp_ihit", h, 1); chk("fp_inew", n, 0); chk("fp_icount", distinct_count, 2);

        rsp_ready = 0;
        do_op(1, 8'h01, h, n, sn, lat);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1); chk("bp_hit", rsp_hit, 0);
            chk("bp_new", rsp_new, 1); chk("bp_ready", req_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_ready_back", req_ready, 1);
        chk("bp_valid_low", rsp_valid, 0);

        clr = 1;
        @(negedge clk); chk("clr_blocks_req", req_ready, 0);
        @(posedge clk); #1 clr = 0;
        count_busy(0, nb);
        chk("clr_len", nb, 8);
        chk("clr_count", distinct_count, 0);
        do_op(0, 8'h00, h, n, sn, lat);
        chk("clr_q00", h, 0);

        rsp_ready = 0;
        do_op(1, 8'h00, h, n, sn, lat);
        clr = 1;
        @(posedge clk); #1 clr = 0; rsp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pend_idle_busy", busy, 0); chk("pend_idle_ready", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pend_clr_busy", busy, 1);
        count_busy(1, nb);
        chk("pend_clr_len", nb, 8);
        chk("pend_clr_count", distinct_count, 0);

        do_op(1, 8'h00, h, n, sn, lat);
        do_op(1, 8'h00, h, n, sn, lat);
        clr = 1;
        @(posedge clk); #1 clr = 0;
        repeat (3) @(posedge clk);
        #1 chk("mid_clr_busy", busy, 1); chk("mid_clr_hit", rsp_hit, 1);
        #1 reset = 1;
        #1;
        chk("rst_mid_valid", rsp_valid, 0); chk("rst_mid_hit", rsp_hit, 0);
        chk("rst_mid_new", rsp_new, 0); chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", distinct_count, 0);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;

        do_op(1, 8'h00, h, n, sn, lat);
        do_op(1, 8'h01, h, n, sn, lat);
        chk("sat_pre", s_count, 2);
        do_op(1, 8'h02, h, n, sn, lat);
        chk("sat_a_new", sn, 1); chk("sat_a_count", s_count, 3);
        do_op(1, 8'h03, h, n, sn, lat);
        chk("sat_b_new", sn, 1); chk("sat_b_count", s_count, 3);
        chk("sat_wide_count", distinct_count, 4);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            req_valid = ($urandom_range(0, 99) < 60);
            req_op    = 1'($urandom_range(0, 1));
            req_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 99) < 70);
            clr       = ($urandom_range(0, 149) == 0);
            if (c == 2000) begin
                #2 reset = 1;
                @(negedge clk); reset = 0;
            end
        end
        @(posedge clk); #1;
        clr = 0; req_valid = 0; rsp_ready = 1;
        repeat (30) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
